serial_addsub: RTL
==================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits (legal values 2 to 64).
REQ-002 Parameter DIGIT, default 1: bits processed per cycle (must divide WIDTH evenly; N = WIDTH/DIGIT).
REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port start, input, 1: request a new operation; sampled on the rising edge of clk.
REQ-006 Port a, input, WIDTH: operand A, two's complement or unsigned.
REQ-007 Port b, input, WIDTH: operand B.
REQ-008 Port mode, input, 1: 0 = add (A+B), 1 = subtract (A-B).
REQ-009 Port busy, output, 1: an operation is in progress.
REQ-010 Port done, output, 1: one-cycle pulse when a result is committed.
REQ-011 Port s, output, WIDTH: registered result.
REQ-012 Port cout, output, 1: carry out of the MSB (in subtract mode, 1 = no borrow).
REQ-013 Port ovf, output, 1: signed overflow, defined as carry into MSB XOR carry out of MSB.
REQ-014 Port zero, output, 1: high when s == 0.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 In IDLE or DONE, start=1 at an edge SHALL do the following at that edge:
- capture a, b and mode into internal shift registers;
- preload the carry register with mode;
- clear the digit counter;
- go to RUN.
REQ-017 Each cycle in RUN SHALL add the lowest DIGIT bits of A to the lowest DIGIT bits of (B XOR {WIDTH{mode}}), plus the carry register, LSB-first.
- The DIGIT sum bits go into the partial result.
- The carry register updates.
- The operand registers shift right by DIGIT.
REQ-018 On the N-th RUN edge, the FSM SHALL go to DONE and commit s, cout, ovf and zero at that same edge.
REQ-019 Latency, for a start sampled at edge 0:
- busy is high from after edge 0 until edge N;
- the result and done are valid from after edge N;
- done stays high for exactly one cycle.
REQ-020 In DONE without start, the FSM SHALL return to IDLE at the next edge.
REQ-021 s, cout, ovf and zero SHALL hold their last committed values until the next commit; they do not change while RUN is in progress.
REQ-022 start while busy=1 SHALL be ignored, and operands presented then SHALL have no effect.
REQ-023 start in DONE SHALL be accepted, giving back-to-back operations every N+1 cycles.
REQ-024 Arithmetic SHALL wrap modulo 2^WIDTH.
- No saturation.
- ovf is computed from the carries at the final digit's MSB position.
REQ-025 a, b and mode SHALL be ignored except at the accepting edge; changing them during RUN does not alter the result.
REQ-026 With DIGIT=WIDTH (N=1), the block SHALL behave as a registered adder/subtractor with done one cycle after start.

Reset
REQ-027 rst=1 SHALL immediately (asynchronously) force the following, regardless of state, including mid-RUN:
- state = IDLE;
- busy = 0, done = 0;
- s = 0, cout = 0, ovf = 0, zero = 1;
- carry, counter and operand registers = 0.
REQ-028 An operation interrupted by reset SHALL be discarded with no result commit.
REQ-029 After rst deasserts, the first accepted start SHALL be at the first edge where rst=0 and start=1.

Verification (WIDTH=8, DIGIT=1 unless stated)
REQ-030 Add: a=100, b=27, mode=0 -> after 8 cycles, s=127, cout=0, ovf=0, zero=0, one-cycle done pulse.
REQ-031 Signed overflow: a=0x7F, b=0x01, mode=0 -> s=0x80, ovf=1, cout=0. Also a=0xFF, b=0x01 -> s=0x00, cout=1, zero=1, ovf=0.
REQ-032 Subtract:
- a=5, b=5, mode=1 -> s=0, cout=1, zero=1, ovf=0;
- a=3, b=5, mode=1 -> s=0xFE, cout=0;
- a=0x80, b=0x01, mode=1 -> s=0x7F, ovf=1.
REQ-033 Protocol:
- start pulsed at cycle 3 of a RUN with different operands -> ignored, and the first result is unchanged;
- start held high in DONE -> second operation completes exactly N+1 cycles after the first done.
REQ-034 Reset mid-op: assert rst at RUN digit 4 -> outputs zero immediately, busy=0, no done pulse; a new start after reset gives the correct result.
REQ-035 Parameter sweep: DIGIT=4 (done 2 cycles after start) and DIGIT=8 (done 1 cycle after start), plus WIDTH=16 with DIGIT=4. Random operands for each, compared against a reference model for s, cout, ovf and zero.

Source files
------------

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle, LSB first,
// and commits the full result, carry, overflow and zero flags after WIDTH/DIGIT cycles.
module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, part_q, part_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

   logic [DIGIT:0]   dsum;
   logic             c_msb_in;
   logic [WIDTH-1:0] part_next;

   // Carry into the digit MSB is recovered from the MSB sum bit: a ^ b ^ sum.
   always_comb begin
      dsum      = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
      c_msb_in  = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
      part_next = WIDTH'({dsum[DIGIT-1:0], part_q} >> DIGIT);
   end

   always_comb begin
      // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      part_d  = part_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b ^ {WIDTH{mode}};
               part_d  = '0;
               carry_d = mode;
               cnt_d   = '0;
               state_d = RUN;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            part_d  = part_next;
            carry_d = dsum[DIGIT];
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
               state_d = DONE;
               s_d     = part_next;
               cout_d  = dsum[DIGIT];
               ovf_d   = c_msb_in ^ dsum[DIGIT];
               zero_d  = (part_next == '0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         part_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         part_q  <= part_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign s    = s_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;

endmodule
